bist_lfsr_engine: RTL and testbench
===================================

# bist_lfsr_engine

Parametrised logic-BIST engine for the multi-chain scan wrappers (s9234_scan and later cores). It drives `NUM_CHAINS` scan inputs from an internal maximal-length LFSR pattern generator. It sequences shift/capture for `NUM_PATTERNS` patterns and compacts scan-chain outputs into a multiple-input signature register (MISR). It replaces the free-running, zero-seeded TPG/compactor pair with a self-timed controller that reports a final signature and an optional pass/fail result.

## Interface
Parameters:
- `NUM_CHAINS`, 7, number of scan chains; equals TPG and MISR width; legal range 3..16.
- `CHAIN_LEN`, 33, shift cycles per pattern (length of the longest chain); must be at least 1.
- `NUM_PATTERNS`, 100, number of capture cycles per run; must be at least 1.
- `TPG_SEED`, 1, TPG value after reset and at run start; must be nonzero.

Ports (one clock; reset is asynchronous and active-high):
- `CK` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: single-cycle run request, sampled in IDLE or DONE.
- `golden_sig` input NUM_CHAINS: expected signature.
- `chain_so` input NUM_CHAINS: scan outputs from the core under test.
- `chain_si` output NUM_CHAINS: scan inputs to the core (TPG state).
- `scan_en` output 1: 1 during shift, 0 during capture or idle.
- `bist_en` output 1: selects `chain_si` over external SI at the core muxes.
- `busy` output 1: run in progress.
- `done` output 1: run complete; held until the next `start`.
- `pass` output 1: signature equals `golden_sig`; valid while `done` is 1.
- `signature` output NUM_CHAINS: MISR contents.

## Operation
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE/DONE + `start`:
  - go to LOAD;
  - TPG is set to `TPG_SEED`, MISR to 0, pattern counter to 0, shift counter to 0.
  - `start` in any other state is ignored.
- LOAD: shifts the first pattern for `CHAIN_LEN` cycles. The MISR is held because the chain contents are unknown. Then go to CAPTURE.
- CAPTURE: lasts 1 cycle. The pattern counter increments.
  - If the counter reaches `NUM_PATTERNS`, go to UNLOAD.
  - Otherwise go to SHIFT.
- SHIFT: lasts `CHAIN_LEN` cycles. The MISR compacts while the next pattern loads. Then go to CAPTURE.
- UNLOAD: lasts `CHAIN_LEN` cycles. The MISR compacts and the TPG keeps advancing (the value loaded is don't-care). Then go to DONE.
- TPG (Fibonacci form): `q_next = {q[N-2:0], fb}`, where `fb` is the XOR of the tap bits from the package table. It advances on every LOAD, SHIFT and UNLOAD cycle and holds in CAPTURE, IDLE and DONE. `chain_si = q`.
- MISR: `m_next = {m[N-2:0], fbm} ^ chain_so`, using the same tap table. It updates only in SHIFT and UNLOAD.
- `pass`: registered compare `signature == golden_sig`, taken on entry to DONE.

## Timing
- Reset values:
  - state IDLE;
  - `chain_si = TPG_SEED`, `signature = 0`;
  - `scan_en`, `bist_en`, `busy`, `done`, `pass` all 0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- `start` is sampled at edge 0. `busy`, `bist_en` and `scan_en` are 1 from the cycle after that edge.
- Run length is `NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN` cycles. `done` rises in the cycle after the last UNLOAD shift.
- `scan_en` is 0 only in CAPTURE, IDLE and DONE.
- `bist_en` is 1 in LOAD through UNLOAD.
- Counters are sized `$clog2(CHAIN_LEN)` and `$clog2(NUM_PATTERNS+1)` bits and never wrap mid-run.
- Reset mid-run: all state returns to reset values asynchronously, and `done` and `pass` are 0.

## Configuration
- `BIST_SIG_CMP_EN`:
  - Defined: the compare logic is present and `pass` behaves as described above.
  - Undefined: `pass` is tied to 0 and `golden_sig` is unused. `signature` remains for off-chip comparison.

## Structure
- Package `bist_pkg` holds:
  - function `lfsr_taps(width)` returning the maximal-length tap mask for widths 3..16 (Xilinx XAPP052 taps; 7 → x^7+x^6+1);
  - the FSM state enum typedef.
- One sub-module, `bist_lfsr`, parametrised by width and seed. It has `load`, `advance` and `inject_en` controls plus a data input, and is instantiated twice: as the TPG with `inject_en = 0` and as the MISR.

## Test plan
All scenarios use NUM_CHAINS=7, CHAIN_LEN=4, NUM_PATTERNS=3 unless stated.
- Reset then idle: outputs at reset values; `chain_si = 7'h01`; `start` held low → outputs stay constant.
- `start` pulse:
  - `chain_si` in the LOAD cycles = 01, 02, 04, 08;
  - CAPTURE holds 10 with `scan_en = 0`;
  - SHIFT presents 10, 20, 41, 03.
- Full run: `busy` high for exactly 19 cycles, then `done = 1`.
- Signature: with `chain_so` tied to 7'h00 throughout, the run ends with `signature = 7'h00`.
- Signature with compare enabled:
  - drive `chain_so = 7'h01` only in the first SHIFT cycle, with `golden_sig` set to the reference-model result → `pass = 1`;
  - flip one bit of `golden_sig` → `pass = 0`.
- Robustness:
  - `reset` asserted mid-SHIFT → async return to IDLE with `done = 0`;
  - `start` during a run is ignored;
  - `start` in DONE restarts the run and clears `done` the next cycle.

Source files
------------

// File: rtl/bist_lfsr_engine_pkg.sv
// bist_pkg: shared FSM state type and maximal-length LFSR tap table for the BIST engine.
package bist_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, DONE} bist_state_e;

    // Bit i of the mask set means stage i+1 of the XAPP052 tap list feeds back.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/bist_lfsr_engine_lfsr.sv
// bist_lfsr: Fibonacci LFSR with synchronous reload and optional parallel input injection (MISR mode).
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter logic [WIDTH-1:0] SEED = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic             inject_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] d_o
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = load_i ? SEED :
              advance_i ? ({q_q[WIDTH-2:0], ^(q_q & TAPS)} ^ (inject_en_i ? data_i : '0)) :
              q_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= SEED;
        else       q_q <= q_d;
    end

    assign q_o = q_q;
    assign d_o = q_d;

endmodule

// File: rtl/bist_lfsr_engine.sv
// bist_lfsr_engine: self-timed logic-BIST controller driving scan chains from an LFSR TPG and compacting into a MISR.
// Define BIST_SIG_CMP_EN to include the golden-signature compare behind the pass output.
module bist_lfsr_engine
    import bist_pkg::*;
#(
    parameter int NUM_CHAINS   = 7,
    parameter int CHAIN_LEN    = 33,
    parameter int NUM_PATTERNS = 100,
    parameter int TPG_SEED     = 1
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] golden_sig,
    input  logic [NUM_CHAINS-1:0] chain_so,
    output logic [NUM_CHAINS-1:0] chain_si,
    output logic                  scan_en,
    output logic                  bist_en,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_CHAINS-1:0] signature
);
    localparam int SCW = CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
    localparam int PCW = $clog2(NUM_PATTERNS + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(CHAIN_LEN - 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(NUM_PATTERNS);

    bist_state_e state_q, state_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic pass_q, pass_d;
    logic start_ok, shifting, compacting, shift_end;
    logic [NUM_CHAINS-1:0] tpg_q, misr_q, misr_d, unused_tpg_d;

    always_comb begin
        start_ok   = start && (state_q == IDLE || state_q == DONE);
        shifting   = state_q == LOAD || state_q == SHIFT || state_q == UNLOAD;
        compacting = state_q == SHIFT || state_q == UNLOAD;
        shift_end  = shifting && sc_q == SC_LAST;
        sc_d       = start_ok ? '0 : shifting ? (shift_end ? '0 : sc_q + 1'b1) : sc_q;
        pc_d       = start_ok ? '0 : state_q == CAPTURE ? pc_q + 1'b1 : pc_q;
        state_d    = start_ok ? LOAD :
                     state_q == CAPTURE ? (pc_d == PC_LAST ? UNLOAD : SHIFT) :
                     !shift_end ? state_q :
                     state_q == UNLOAD ? DONE : CAPTURE;
`ifdef BIST_SIG_CMP_EN
        // Compare against the MISR's next value so pass is valid in the first DONE cycle.
        pass_d     = start_ok ? 1'b0 :
                     (state_q == UNLOAD && shift_end) ? (misr_d == golden_sig) : pass_q;
`else
        pass_d     = 1'b0;
`endif
    end

`ifndef BIST_SIG_CMP_EN
    logic unused_cmp;
    assign unused_cmp = ^{golden_sig, misr_d};
`endif

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sc_q    <= '0;
            pc_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            pc_q    <= pc_d;
            pass_q  <= pass_d;
        end
    end

    bist_lfsr #(.WIDTH(NUM_CHAINS), .SEED(NUM_CHAINS'(TPG_SEED))) u_tpg (
        .clk_i       (CK),
        .rst_i       (reset),
        .load_i      (start_ok),
        .advance_i   (shifting),
        .inject_en_i (1'b0),
        .data_i      ('0),
        .q_o         (tpg_q),
        .d_o         (unused_tpg_d)
    );

    bist_lfsr #(.WIDTH(NUM_CHAINS), .SEED('0)) u_misr (
        .clk_i       (CK),
        .rst_i       (reset),
        .load_i      (start_ok),
        .advance_i   (compacting),
        .inject_en_i (1'b1),
        .data_i      (chain_so),
        .q_o         (misr_q),
        .d_o         (misr_d)
    );

    assign chain_si  = tpg_q;
    assign signature = misr_q;
    assign scan_en   = shifting;
    assign busy      = state_q != IDLE && state_q != DONE;
    assign bist_en   = busy;
    assign done      = state_q == DONE;
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_lfsr_engine.sv
// tb_bist_lfsr_engine: randomized self-checking bench with a run-level behavioural model of the BIST engine.
module tb_bist_lfsr_engine;
    localparam int N = 7;
    localparam int L = 4;
    localparam int P = 3;
    localparam int R = P * (L + 1) + L;
`ifdef BIST_SIG_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic CK = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [N-1:0] golden_sig = '0;
    logic [N-1:0] chain_so = '0;
    logic [N-1:0] chain_si, signature;
    logic scan_en, bist_en, busy, done, pass;

    always #5 CK = ~CK;

    bist_lfsr_engine #(.NUM_CHAINS(N), .CHAIN_LEN(L), .NUM_PATTERNS(P), .TPG_SEED(1)) dut (
        .CK         (CK),
        .reset      (reset),
        .start      (start),
        .golden_sig (golden_sig),
        .chain_so   (chain_so),
        .chain_si   (chain_si),
        .scan_en    (scan_en),
        .bist_en    (bist_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    bit m_run, m_done, m_pass;
    int m_t;
    logic [N-1:0] m_tpg, m_misr;
    logic [N-1:0] so_buf [R];
    logic [N-1:0] seq_tab [9] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h10, 7'h20, 7'h41, 7'h03};

    // x^7 + x^6 + 1 applied to a 7-bit shift-left register.
    function automatic logic [N-1:0] lstep(input logic [N-1:0] q);
        return {q[N-2:0], q[6] ^ q[5]};
    endfunction

    // Run cycle t is a capture when it closes the first load or any later shift window.
    function automatic bit is_cap(input int t);
        return t >= L && (t - L) % (L + 1) == 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pass = 0; m_t = 0; m_tpg = 7'h01; m_misr = '0;
    endtask

    task automatic model_step();
        bit cap;
        if (m_run) begin
            cap = is_cap(m_t);
            if (!cap) m_tpg = lstep(m_tpg);
            if (!cap && m_t >= L) m_misr = lstep(m_misr) ^ chain_so;
            m_t++;
            if (m_t == R) begin
                m_run = 0;
                m_done = 1;
                m_pass = CMP && (m_misr == golden_sig);
            end
        end else if (start) begin
            m_run = 1; m_t = 0; m_tpg = 7'h01; m_misr = '0; m_done = 0; m_pass = 0;
        end
    endtask

    task automatic tick();
        @(posedge CK);
        model_step();
        #2;
    endtask

    always @(negedge CK) begin
        if (chk_en) begin
            chk("busy", busy, m_run);
            chk("bist_en", bist_en, m_run);
            chk("scan_en", scan_en, m_run && !is_cap(m_t));
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("chain_si", chain_si, m_tpg);
            chk("signature", signature, m_misr);
        end
    end

    // mode 0: chain_so zero, 1: single 01 in first SHIFT cycle, 2: replay so_buf.
    task automatic do_run(input int mode, input bit poke, input bit seqchk);
        int busy_cnt = 0;
        bit got_done = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_cleared", done, 0);
        for (int i = 0; i < R + 6 && !got_done; i++) begin
            chain_so = mode == 0 ? 7'h00 : mode == 1 ? (i == L + 1 ? 7'h01 : 7'h00) : so_buf[i % R];
            start = poke && i == 7;
            if (seqchk && i < 9) chk("seq_chain_si", chain_si, seq_tab[i]);
            if (seqchk && i == 4) chk("cap_scan_en", scan_en, 0);
            if (busy) busy_cnt++;
            if (done) got_done = 1;
            else tick();
        end
        start = 1'b0;
        chain_so = '0;
        chk("run_len", busy_cnt, R);
        chk("done_seen", got_done, 1);
    endtask

    task automatic mid_reset();
        chk_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_scan_en", scan_en, 0);
        chk("rst_bist_en", bist_en, 0);
        chk("rst_chain_si", chain_si, 7'h01);
        chk("rst_sig", signature, 7'h00);
        model_reset();
        @(posedge CK);
        #2 reset = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        logic [N-1:0] sig;
        model_reset();
        repeat (2) @(posedge CK);
        #2 reset = 1'b0;
        chk("init_chain_si", chain_si, 7'h01);
        chk("init_sig", signature, 7'h00);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_pass", pass, 0);
        chk("init_scan_en", scan_en, 0);
        chk("init_bist_en", bist_en, 0);
        chk_en = 1'b1;
        repeat (4) tick();
        chk("idle_chain_si", chain_si, 7'h01);

        do_run(0, 0, 1);
        chk("zero_sig", signature, 7'h00);

        golden_sig = 7'h30;
        do_run(1, 0, 0);
        chk("model_sig", m_misr, 7'h30);
        chk("pulse_sig", signature, 7'h30);
        chk("pulse_pass", pass, CMP);

        golden_sig = 7'h30 ^ 7'(1 << $urandom_range(0, 6));
        do_run(1, 1, 0);
        chk("flip_pass", pass, 0);
        chk("flip_sig", signature, 7'h30);

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < R; j++) so_buf[j] = 7'($urandom);
            golden_sig = 7'($urandom);
            do_run(2, k[0], 0);
            sig = m_misr;
            golden_sig = sig;
            repeat ($urandom_range(0, 3)) tick();
            do_run(2, 0, 0);
            chk("rand_pass", pass, CMP);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_busy", busy, 1);
        mid_reset();
        repeat (2) tick();
        do_run(0, 0, 1);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
